// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers.
// Used by inv_key_expansion; optional INV_KEY_MIXCOL_EN lives in the top.
package aes_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t EMIT = 1'b1;

  localparam logic [7:0] RCON_LAST = 8'h36;
  localparam logic [7:0] RCON_INV_POLY = 8'h8D;
  localparam logic [3:0] NUM_ROUNDS = 4'd10;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Undo one xtime step: walks the rcon chain backwards.
  function automatic logic [7:0] rcon_inv(
    input logic [7:0] r
  );
    return (r >> 1) ^ (r[0] ? RCON_INV_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/inv_key_expansion_if.sv
// Handshake bundle between the reverse key schedule and its consumer.
// master drives requests and ready, slave returns the key beats.
interface inv_key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic         out_ready;
  logic [127:0] key_out;
  logic [3:0]   round_out;
  logic         key_valid;
  logic         key_last;
  logic         busy;

  modport master (
    output start, key_in, out_ready,
    input  key_out, round_out, key_valid,
    input  key_last, busy
  );

  modport slave (
    input  start, key_in, out_ready,
    output key_out, round_out, key_valid,
    output key_last, busy
  );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, one byte, purely combinational.
// Byte n of the table sits at bits [2047-8n -: 8].
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] idx;

  assign idx = 11'h7FF - {x, 3'b000};
  assign s = TABLE[idx -: 8];
endmodule

// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule, emits round keys 10 down to 0.
// Define INV_KEY_MIXCOL_EN to output equivalent inverse cipher keys.
import aes_pkg::*;

module inv_key_expansion (
  input logic CLK,
  input logic reset,
  inv_key_expansion_if.slave bus
);
  state_t       state;
  logic [127:0] key;
  logic [3:0]   round;
  logic [7:0]   rcon;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  n1, n2, n3;
  logic [31:0]  rot, sub;
  logic [127:0] prev;
  logic         emit, xfer;

  assign {w0, w1, w2, w3} = key;
  assign n3 = w3 ^ w2;
  assign n2 = w2 ^ w1;
  assign n1 = w1 ^ w0;
  assign rot = {n3[23:0], n3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .x (rot[8*i +: 8]),
      .s (sub[8*i +: 8])
    );
  end

  assign prev = {w0 ^ sub ^ {rcon, 24'h0}, n1, n2, n3};
  assign emit = (state == EMIT);
  assign xfer = emit && bus.out_ready;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= IDLE;
      key   <= '0;
      round <= '0;
      rcon  <= '0;
    end else begin
      unique case (1'b1)
        !emit: begin
          if (bus.start) begin
            state <= EMIT;
            key   <= bus.key_in;
            round <= NUM_ROUNDS;
            rcon  <= RCON_LAST;
          end
        end
        xfer && round != 4'd0: begin
          key   <= prev;
          round <= round - 4'd1;
          rcon  <= rcon_inv(rcon);
        end
        xfer && round == 4'd0: state <= IDLE;
        default: ;
      endcase
    end
  end

  assign bus.round_out = round;
  assign bus.key_valid = emit;
  assign bus.busy      = emit;
  assign bus.key_last  = emit && (round == 4'd0);

`ifdef INV_KEY_MIXCOL_EN
  function automatic logic [7:0] gm(
    input logic [7:0] b,
    input logic [3:0] c
  );
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00)
         ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
  endfunction

  function automatic logic [31:0] imc(
    input logic [31:0] col
  );
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {
      gm(a0, 4'd14) ^ gm(a1, 4'd11) ^ gm(a2, 4'd13) ^ gm(a3, 4'd9),
      gm(a0, 4'd9)  ^ gm(a1, 4'd14) ^ gm(a2, 4'd11) ^ gm(a3, 4'd13),
      gm(a0, 4'd13) ^ gm(a1, 4'd9)  ^ gm(a2, 4'd14) ^ gm(a3, 4'd11),
      gm(a0, 4'd11) ^ gm(a1, 4'd13) ^ gm(a2, 4'd9)  ^ gm(a3, 4'd14)
    };
  endfunction

  logic [127:0] mixed;
  logic         raw;

  assign mixed = {imc(w0), imc(w1), imc(w2), imc(w3)};
  assign raw = (round == 4'd0) || (round == NUM_ROUNDS);
  assign bus.key_out = raw ? key : mixed;
`else
  assign bus.key_out = key;
`endif

endmodule

// File: tb/tb_inv_key_expansion.sv
// Directed bench for inv_key_expansion with a beat scoreboard.
// Build with +define+INV_KEY_MIXCOL_EN to check the mixed key path.
module tb_inv_key_expansion;

  logic clk = 1'b0;
  logic rst;

  inv_key_expansion_if bus ();

  inv_key_expansion dut (
    .CLK   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   r;
    logic [127:0] k;
    logic         last;
  } beat_t;

  beat_t        sb[$];
  logic [127:0] rk[11];
  int           n_vec = 0;
  int           n_bad = 0;

  task automatic chk(input string tag,
                     input logic [127:0] o,
                     input logic [127:0] e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return b[7] ? ((b << 1) ^ 8'h1B) : (b << 1);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sb_ref(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    for (int c = 1; c < 256; c++)
      if (gmul(x, 8'(c)) == 8'h01) v = 8'(c);
    return v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] imc_ref(input logic [31:0] c);
    logic [7:0] a[4];
    logic [7:0] m[4];
    logic [7:0] co[4];
    co = '{8'd14, 8'd11, 8'd13, 8'd9};
    for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
    for (int r = 0; r < 4; r++) begin
      m[r] = 8'h00;
      for (int j = 0; j < 4; j++)
        m[r] = m[r] ^ gmul(a[j], co[(j - r + 4) % 4]);
    end
    return {m[0], m[1], m[2], m[3]};
  endfunction

  function automatic logic [127:0] exp_key(input int r);
`ifdef INV_KEY_MIXCOL_EN
    if (r != 0 && r != 10)
      return {imc_ref(rk[r][127:96]), imc_ref(rk[r][95:64]),
              imc_ref(rk[r][63:32]), imc_ref(rk[r][31:0])};
`endif
    return rk[r];
  endfunction

  // Forward expansion from round 0, then queue beats 10..0.
  task automatic push_seq(input logic [127:0] k0);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_ref(t[31:24]), sb_ref(t[23:16]),
             sb_ref(t[15:8]), sb_ref(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 10; r >= 0; r--)
      sb.push_back('{r: 4'(r), k: exp_key(r), last: (r == 0)});
  endtask

  always @(negedge clk) begin
    beat_t e;
    if (bus.key_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("extra_beat", {124'h0, bus.round_out}, 128'hF);
      end else begin
        e = sb.pop_front();
        chk("beat_round", {124'h0, bus.round_out}, {124'h0, e.r});
        chk("beat_key", bus.key_out, e.k);
        chk("beat_last", {127'h0, bus.key_last}, {127'h0, e.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beat(input logic [3:0] r);
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.key_valid && bus.round_out == r) break;
    end
    chk("wait_round", {127'h0, i < 40}, 128'h1);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk("wait_idle", {127'h0, i < 40}, 128'h1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_key"}, bus.key_out, 128'h0);
    chk({tag, "_round"}, {124'h0, bus.round_out}, 128'h0);
    chk({tag, "_valid"}, {127'h0, bus.key_valid}, 128'h0);
    chk({tag, "_last"}, {127'h0, bus.key_last}, 128'h0);
    chk({tag, "_busy"}, {127'h0, bus.busy}, 128'h0);
  endtask

  localparam logic [127:0] K0A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K0B = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst = 1'b0;
    bus.start = 1'b1;
    bus.key_in = 128'hdeadbeef_00112233_44556677_8899aabb;
    bus.out_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst = 1'b1;
    bus.start = 1'b0;
    tick();
    @(negedge clk);
    chk("start_in_reset", {127'h0, bus.key_valid}, 128'h0);

    // Continuous run: 11 beats on 11 cycles.
    push_seq(K0B);
    tick();
    bus.key_in = rk[10];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.key_valid) break;
      cyc++;
    end
    chk("beat_count", 128'(cyc), 128'd11);
    chk("done_busy", {127'h0, bus.busy}, 128'h0);
    chk("model_r10", rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Start pulses during busy, then back-to-back restart.
    push_seq(K0A);
    tick();
    bus.key_in = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("first_key", bus.key_out, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("first_round", {124'h0, bus.round_out}, 128'd10);
    wait_beat(4'd8);
    tick();
    bus.start = 1'b1;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    tick();
    bus.start = 1'b0;
    wait_beat(4'd1);
    tick();
    bus.start = 1'b1;
    push_seq(K0B);
    bus.key_in = rk[10];
    tick();
    @(negedge clk);
    chk("gap_busy", {127'h0, bus.busy}, 128'h0);
    chk("gap_valid", {127'h0, bus.key_valid}, 128'h0);
    tick();
    bus.start = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};

    // Back-pressure at round 5 for three cycles.
    wait_beat(4'd6);
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_round", {124'h0, bus.round_out}, 128'd5);
      chk("stall_key", bus.key_out, exp_key(5));
      chk("stall_valid", {127'h0, bus.key_valid}, 128'h1);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_idle();
    chk("sb_empty_1", 128'(sb.size()), 128'h0);

    // Reset in the middle of a sequence.
    push_seq(K0A);
    bus.key_in = rk[10];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_beat(4'd5);
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_zero("abort");
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("abort_idle", {127'h0, bus.key_valid}, 128'h0);
    end

    // Clean sequence after the abort.
    tick();
    push_seq(K0B);
    bus.key_in = rk[10];
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle();
    chk("sb_empty_2", 128'(sb.size()), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
